// File: rtl/registrador_universal.sv
// Universal register: parallel load plus multi-cycle shift/rotate, one step per clock.
// Optional macro REGISTRADOR_PARITY_EN adds a combinational even-parity output.
module registrador_universal #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BITS-1:0]  in,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [BITS-1:0]  out,
  output logic             serial_out,
  output logic             busy,
`ifdef REGISTRADOR_PARITY_EN
  output logic             done,
  output logic             parity
`else
  output logic             done
`endif
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [BITS-1:0]  out_q, out_d;
  logic             so_q, so_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          out_d = in;
        end else if (start) begin
          if (amount != '0) begin
            mode_d  = mode;
            cnt_d   = amount;
            busy_d  = 1'b1;
            state_d = StShift;
          end else begin
            // Zero-length operation completes immediately.
            done_d = 1'b1;
          end
        end
      end
      StShift: begin
        unique case (mode_q)
          2'b00: begin
            out_d = {out_q[BITS-2:0], serial_in};
            so_d  = out_q[BITS-1];
          end
          2'b01: begin
            out_d = {serial_in, out_q[BITS-1:1]};
            so_d  = out_q[0];
          end
          2'b10: begin
            out_d = {out_q[BITS-2:0], out_q[BITS-1]};
            so_d  = out_q[BITS-1];
          end
          default: begin
            out_d = {out_q[0], out_q[BITS-1:1]};
            so_d  = out_q[0];
          end
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign out        = out_q;
  assign serial_out = so_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef REGISTRADOR_PARITY_EN
  assign parity = ^out_q;
`endif

endmodule

// File: tb/tb_registrador_universal.sv
// Directed self-checking bench for registrador_universal (8-bit, 3-bit amount).
module tb_registrador_universal;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       load;
  logic       start;
  logic [1:0] mode;
  logic [2:0] amount;
  logic       serial_in;
  logic [7:0] out;
  logic       serial_out;
  logic       busy;
  logic       done;
`ifdef REGISTRADOR_PARITY_EN
  logic       parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  registrador_universal #(.BITS(8), .AMT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .load       (load),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .serial_in  (serial_in),
    .out        (out),
    .serial_out (serial_out),
    .busy       (busy),
`ifdef REGISTRADOR_PARITY_EN
    .done       (done),
    .parity     (parity)
`else
    .done       (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample point is 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    in   = v;
    step();
    load = 1'b0;
  endtask

  // Issue a command and watch the following cycles, capturing the result at done.
  task automatic run_op(input logic [1:0] m, input logic [2:0] a, input logic si,
                        input bit noise, output logic [7:0] cap_out, output logic cap_so,
                        output int busy_cnt, output int done_cnt);
    start     = 1'b1;
    mode      = m;
    amount    = a;
    serial_in = si;
    step();
    if (noise) begin
      load   = 1'b1;
      in     = 8'hFF;
      mode   = ~m;
      amount = 3'd7;
    end else begin
      start = 1'b0;
    end
    busy_cnt = 0;
    done_cnt = 0;
    cap_out  = 8'h00;
    cap_so   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        cap_out = out;
        cap_so  = serial_out;
      end
      step();
    end
    load  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] r_out;
    logic       r_so;
    int         b_cnt, d_cnt;

    rst = 1'b1; in = '0; load = 1'b0; start = 1'b0; mode = 2'b00; amount = '0; serial_in = 1'b0;
    step();
    step();
    check("rst_out", out, 8'h00);
    check("rst_so", serial_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    // Abort a shl by 7 mid-run
    do_load(8'hFF);
    start = 1'b1; mode = 2'b00; amount = 3'd7; serial_in = 1'b0;
    step();
    start = 1'b0;
    check("abort_busy_pre", busy, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("abort_out", out, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_so", serial_out, 1'b0);
    d_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) d_cnt++;
      step();
    end
    check("abort_no_done", d_cnt, 0);

    // load beats start
    load = 1'b1; in = 8'b01010101; start = 1'b1; amount = 3'd3;
    step();
    load = 1'b0; start = 1'b0;
    check("load_wins_out", out, 8'h55);
    check("load_wins_busy", busy, 1'b0);
    check("load_wins_done", done, 1'b0);

    run_op(2'b00, 3'd3, 1'b0, 1'b0, r_out, r_so, b_cnt, d_cnt);
    check("shl3_out", r_out, 8'hA8);
    check("shl3_so", r_so, 1'b0);
    check("shl3_busy", b_cnt, 3);
    check("shl3_done", d_cnt, 1);

    do_load(8'h81);
    run_op(2'b01, 3'd2, 1'b1, 1'b0, r_out, r_so, b_cnt, d_cnt);
    check("shr2_out", r_out, 8'hE0);
    check("shr2_so", r_so, 1'b0);
    check("shr2_busy", b_cnt, 2);

    do_load(8'hA5);
    run_op(2'b11, 3'd4, 1'b0, 1'b0, r_out, r_so, b_cnt, d_cnt);
    check("rotr4_out", r_out, 8'h5A);
    check("rotr4_so", r_so, 1'b0);
    check("rotr4_busy", b_cnt, 4);

    do_load(8'h3C);
    run_op(2'b00, 3'd0, 1'b1, 1'b0, r_out, r_so, b_cnt, d_cnt);
    check("amt0_out", r_out, 8'h3C);
    check("amt0_busy", b_cnt, 0);
    check("amt0_done", d_cnt, 1);

    // Inputs changing while busy must be ignored
    do_load(8'h01);
    run_op(2'b10, 3'd3, 1'b0, 1'b1, r_out, r_so, b_cnt, d_cnt);
    check("busy_ign_out", r_out, 8'h08);
    check("busy_ign_busy", b_cnt, 3);
    check("busy_ign_done", d_cnt, 1);

    // serial_out holds across a load
    do_load(8'hAA);
    run_op(2'b00, 3'd1, 1'b0, 1'b0, r_out, r_so, b_cnt, d_cnt);
    check("shl1_out", r_out, 8'h54);
    check("shl1_so", r_so, 1'b1);
    do_load(8'h00);
    check("so_hold", serial_out, 1'b1);

`ifdef REGISTRADOR_PARITY_EN
    do_load(8'h07);
    check("parity_07", parity, 1'b1);
    do_load(8'h03);
    check("parity_03", parity, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
